branch_pred_multi: RTL and testbench

Parametrised successor to `branch_pred`: a 2-bit-counter pattern-history-table (PHT) predictor with a speculative global history register (GHR) that tracks up to 2^MAX_INFLIGHT_POW2 unresolved branches instead of stalling on the second one. It sits between `instr_fetch_unit` and the branch ALU.
- **Fetch side:** gives the fetch unit the predicted next PC and a stall.
- **Branch ALU side:** accepts in-order resolutions. On a misprediction it emits a flush plus the recovery PC, and restores the speculative history.

---
 rtl/data_types.sv | 17 +
 rtl/br_ckpt_queue.sv | 46 ++++
 rtl/branch_pred_multi.sv | 84 ++++++++
 tb/tb_branch_pred_multi.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/data_types.sv
// data_types: shared word, PHT counter and branch checkpoint types for the branch predictor.
package data_types;
   typedef logic [31:0] word32_t;
   typedef logic [1:0] pht_cnt_t;
   localparam pht_cnt_t PHT_RESET = 2'b01;
   localparam int CKPT_IDX_W = 16;
   localparam int CKPT_GHR_W = 16;
   typedef struct packed {
      logic [CKPT_IDX_W-1:0] idx;
      logic                  pred;
      word32_t               alt_pc;
      logic [CKPT_GHR_W-1:0] ghr;
   } br_ckpt_t;
   function automatic pht_cnt_t pht_sat(input pht_cnt_t c, input logic up);
      return up ? ((c == 2'b11) ? c : c + 2'b01) : ((c == 2'b00) ? c : c - 2'b01);
   endfunction
endpackage

// File: rtl/br_ckpt_queue.sv
// br_ckpt_queue: circular queue of branch checkpoints with synchronous clear.
module br_ckpt_queue
   import data_types::*;
#(
   parameter int DEPTH_POW2 = 2
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                clear_i,
   input  logic                push_i,
   input  logic                pop_i,
   input  br_ckpt_t            din_i,
   output br_ckpt_t            head_o,
   output logic [DEPTH_POW2:0] count_o,
   output logic                full_o,
   output logic                empty_o
);
   localparam int DEPTH = 1 << DEPTH_POW2;
   br_ckpt_t mem [DEPTH];
   logic [DEPTH_POW2-1:0] wr_ptr;
   logic [DEPTH_POW2-1:0] rd_ptr;
   logic do_push;
   logic do_pop;
   assign full_o  = count_o == (DEPTH_POW2+1)'(DEPTH);
   assign empty_o = count_o == '0;
   assign do_push = push_i & !full_o;
   assign do_pop  = pop_i & !empty_o;
   assign head_o  = mem[rd_ptr];
   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_o <= '0;
      end else if (clear_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_o <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count_o <= count_o + (DEPTH_POW2+1)'(do_push) - (DEPTH_POW2+1)'(do_pop);
      end
   // payload needs no reset; validity is carried by the pointers
   always_ff @(posedge clk_i)
      if (do_push && !clear_i) mem[wr_ptr] <= din_i;
endmodule

// File: rtl/branch_pred_multi.sv
// branch_pred_multi: 2-bit PHT predictor with speculative GHR and a checkpoint queue of in-flight branches.
// Define BR_PRED_GSHARE_EN for a gshare index (PC xor GHR); otherwise the index is bimodal (PC only).
module branch_pred_multi
   import data_types::*;
#(
   parameter int HISTORY_BITS      = 3,
   parameter int PHT_IDX_BITS      = 6,
   parameter int IMM_WIDTH         = 12,
   parameter int MAX_INFLIGHT_POW2 = 2
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  word32_t                    program_counter_i,
   input  logic [IMM_WIDTH-1:0]       jump_imm_i,
   input  logic                       issuing_branch_i,
   output logic                       br_taken_o,
   output word32_t                    program_counter_branched_o,
   output logic                       stall_o,
   input  logic                       cond_eval_i,
   input  logic                       corr_pred_i,
   output logic                       flush_o,
   output word32_t                    recover_pc_o,
   output logic [MAX_INFLIGHT_POW2:0] inflight_o
);
   localparam int PHT_SIZE = 1 << PHT_IDX_BITS;
   pht_cnt_t pht [PHT_SIZE];
   logic [HISTORY_BITS-1:0] ghr;
   logic [HISTORY_BITS-1:0] head_ghr;
   logic [PHT_IDX_BITS-1:0] idx;
   logic [PHT_IDX_BITS-1:0] head_idx;
   word32_t target;
   word32_t pc_plus4;
   br_ckpt_t push_ckpt;
   br_ckpt_t head;
   logic full;
   logic empty;
   logic resolve;
   logic mispred;
   logic alloc;
   logic actual;
   logic unused_ckpt_bits;
   assign pc_plus4 = program_counter_i + 32'd4;
   assign target   = program_counter_i + {{(30-IMM_WIDTH){jump_imm_i[IMM_WIDTH-1]}}, jump_imm_i, 2'b00};
`ifdef BR_PRED_GSHARE_EN
   assign idx = program_counter_i[PHT_IDX_BITS+1:2] ^ PHT_IDX_BITS'(ghr);
`else
   assign idx = program_counter_i[PHT_IDX_BITS+1:2];
`endif
   assign br_taken_o                 = issuing_branch_i & pht[idx][1];
   assign program_counter_branched_o = br_taken_o ? target : pc_plus4;
   assign resolve      = cond_eval_i & !empty;
   assign mispred      = resolve & !corr_pred_i;
   assign alloc        = issuing_branch_i & !full & !mispred;
   assign actual       = corr_pred_i ? head.pred : !head.pred;
   assign head_idx     = head.idx[PHT_IDX_BITS-1:0];
   assign head_ghr     = head.ghr[HISTORY_BITS-1:0];
   assign stall_o      = full;
   assign flush_o      = mispred;
   assign recover_pc_o = mispred ? head.alt_pc : '0;
   assign push_ckpt = '{idx: CKPT_IDX_W'(idx), pred: br_taken_o,
                        alt_pc: br_taken_o ? pc_plus4 : target, ghr: CKPT_GHR_W'(ghr)};
   assign unused_ckpt_bits = ^{head.idx[CKPT_IDX_W-1:PHT_IDX_BITS], head.ghr[CKPT_GHR_W-1:HISTORY_BITS]};
   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) begin
         for (int i = 0; i < PHT_SIZE; i++) pht[i] <= PHT_RESET;
         ghr <= '0;
      end else begin
         if (resolve) pht[head_idx] <= pht_sat(pht[head_idx], actual);
         if (mispred) ghr <= {head_ghr[HISTORY_BITS-2:0], actual};
         else if (alloc) ghr <= {ghr[HISTORY_BITS-2:0], br_taken_o};
      end
   br_ckpt_queue #(.DEPTH_POW2(MAX_INFLIGHT_POW2)) u_queue (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clear_i (mispred),
      .push_i  (alloc),
      .pop_i   (resolve),
      .din_i   (push_ckpt),
      .head_o  (head),
      .count_o (inflight_o),
      .full_o  (full),
      .empty_o (empty)
   );
endmodule

// File: tb/tb_branch_pred_multi.sv
// tb_branch_pred_multi: directed bench for branch_pred_multi in its default (bimodal) build.
module tb_branch_pred_multi;
   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic [31:0] program_counter_i = '0;
   logic [11:0] jump_imm_i = '0;
   logic        issuing_branch_i = 1'b0;
   logic        cond_eval_i = 1'b0;
   logic        corr_pred_i = 1'b0;
   logic        br_taken_o;
   logic [31:0] program_counter_branched_o;
   logic        stall_o;
   logic        flush_o;
   logic [31:0] recover_pc_o;
   logic [2:0]  inflight_o;
   int checks = 0;
   int failures = 0;

   branch_pred_multi dut (
      .clk_i(clk_i), .reset_i(reset_i), .program_counter_i(program_counter_i),
      .jump_imm_i(jump_imm_i), .issuing_branch_i(issuing_branch_i), .br_taken_o(br_taken_o),
      .program_counter_branched_o(program_counter_branched_o), .stall_o(stall_o),
      .cond_eval_i(cond_eval_i), .corr_pred_i(corr_pred_i), .flush_o(flush_o),
      .recover_pc_o(recover_pc_o), .inflight_o(inflight_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic [31:0] pc, input logic [11:0] imm, input logic iss,
                        input logic ce, input logic cp);
      program_counter_i = pc;
      jump_imm_i = imm;
      issuing_branch_i = iss;
      cond_eval_i = ce;
      corr_pred_i = cp;
      #1;
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      drive(32'd12, 12'd5, 1'b1, 1'b0, 1'b0);
      checks++; if (br_taken_o !== 1'b0) begin failures++; $display("FAIL reset_taken got=%b exp=0", br_taken_o); end
      checks++; if (program_counter_branched_o !== 32'd16) begin failures++; $display("FAIL reset_pcb got=%0d exp=16", program_counter_branched_o); end
      tick();
      tick();
      checks++; if (inflight_o !== 3'd0) begin failures++; $display("FAIL reset_inflight got=%0d exp=0", inflight_o); end
      checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
      checks++; if (flush_o !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", flush_o); end
      checks++; if (recover_pc_o !== 32'd0) begin failures++; $display("FAIL reset_recover got=%0d exp=0", recover_pc_o); end
      drive(32'd0, 12'd0, 1'b0, 1'b0, 1'b0);
      reset_i = 1'b0;
      #1;
      checks++; if (dut.ghr !== 3'b000) begin failures++; $display("FAIL reset_ghr got=%b exp=000", dut.ghr); end
   endtask

   task automatic test_empty_resolve();
      drive(32'd0, 12'd0, 1'b0, 1'b1, 1'b0);
      checks++; if (flush_o !== 1'b0) begin failures++; $display("FAIL empty_flush got=%b exp=0", flush_o); end
      tick();
      checks++; if (inflight_o !== 3'd0) begin failures++; $display("FAIL empty_inflight got=%0d exp=0", inflight_o); end
      drive(32'd0, 12'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_alloc();
      drive(32'd12, 12'd5, 1'b1, 1'b0, 1'b0);
      checks++; if (br_taken_o !== 1'b0) begin failures++; $display("FAIL alloc_taken got=%b exp=0", br_taken_o); end
      checks++; if (program_counter_branched_o !== 32'd16) begin failures++; $display("FAIL alloc_pcb got=%0d exp=16", program_counter_branched_o); end
      tick();
      drive(32'd0, 12'd0, 1'b0, 1'b0, 1'b0);
      checks++; if (inflight_o !== 3'd1) begin failures++; $display("FAIL alloc_inflight got=%0d exp=1", inflight_o); end
      checks++; if (dut.ghr !== 3'b000) begin failures++; $display("FAIL alloc_ghr got=%b exp=000", dut.ghr); end
   endtask

   task automatic test_mispredict();
      drive(32'd0, 12'd0, 1'b0, 1'b1, 1'b0);
      checks++; if (flush_o !== 1'b1) begin failures++; $display("FAIL mis_flush got=%b exp=1", flush_o); end
      checks++; if (recover_pc_o !== 32'd32) begin failures++; $display("FAIL mis_recover got=%0d exp=32", recover_pc_o); end
      tick();
      drive(32'd0, 12'd0, 1'b0, 1'b0, 1'b0);
      checks++; if (flush_o !== 1'b0) begin failures++; $display("FAIL mis_flush_clear got=%b exp=0", flush_o); end
      checks++; if (inflight_o !== 3'd0) begin failures++; $display("FAIL mis_inflight got=%0d exp=0", inflight_o); end
      checks++; if (dut.ghr !== 3'b001) begin failures++; $display("FAIL mis_ghr got=%b exp=001", dut.ghr); end
      checks++; if (dut.pht[3] !== 2'b10) begin failures++; $display("FAIL mis_pht got=%b exp=10", dut.pht[3]); end
      drive(32'd12, 12'd5, 1'b1, 1'b0, 1'b0);
      checks++; if (br_taken_o !== 1'b1) begin failures++; $display("FAIL mis_repredict got=%b exp=1", br_taken_o); end
      checks++; if (program_counter_branched_o !== 32'd32) begin failures++; $display("FAIL mis_target got=%0d exp=32", program_counter_branched_o); end
      drive(32'd0, 12'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_full();
      for (int i = 0; i < 4; i++) begin
         drive(32'd36, 12'd3, 1'b1, 1'b0, 1'b0);
         checks++; if (program_counter_branched_o !== 32'd40) begin failures++; $display("FAIL full_pcb%0d got=%0d exp=40", i, program_counter_branched_o); end
         tick();
         checks++; if (inflight_o !== 3'(i + 1)) begin failures++; $display("FAIL full_inflight%0d got=%0d exp=%0d", i, inflight_o, i + 1); end
         checks++; if (stall_o !== (i == 3)) begin failures++; $display("FAIL full_stall%0d got=%b exp=%b", i, stall_o, i == 3); end
      end
      tick();
      checks++; if (inflight_o !== 3'd4) begin failures++; $display("FAIL full_ignored got=%0d exp=4", inflight_o); end
      checks++; if (dut.ghr !== 3'b000) begin failures++; $display("FAIL full_ghr got=%b exp=000", dut.ghr); end
   endtask

   task automatic test_full_resolve();
      drive(32'd36, 12'd3, 1'b1, 1'b1, 1'b1);
      checks++; if (flush_o !== 1'b0) begin failures++; $display("FAIL fullres_flush got=%b exp=0", flush_o); end
      tick();
      drive(32'd0, 12'd0, 1'b0, 1'b0, 1'b0);
      checks++; if (inflight_o !== 3'd3) begin failures++; $display("FAIL fullres_inflight got=%0d exp=3", inflight_o); end
      checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL fullres_stall got=%b exp=0", stall_o); end
      checks++; if (dut.pht[9] !== 2'b00) begin failures++; $display("FAIL fullres_pht got=%b exp=00", dut.pht[9]); end
   endtask

   task automatic test_mispredict_issue();
      drive(32'd12, 12'd5, 1'b1, 1'b1, 1'b0);
      checks++; if (br_taken_o !== 1'b1) begin failures++; $display("FAIL misiss_taken got=%b exp=1", br_taken_o); end
      checks++; if (flush_o !== 1'b1) begin failures++; $display("FAIL misiss_flush got=%b exp=1", flush_o); end
      checks++; if (recover_pc_o !== 32'd48) begin failures++; $display("FAIL misiss_recover got=%0d exp=48", recover_pc_o); end
      tick();
      drive(32'd0, 12'd0, 1'b0, 1'b0, 1'b0);
      checks++; if (inflight_o !== 3'd0) begin failures++; $display("FAIL misiss_inflight got=%0d exp=0", inflight_o); end
      checks++; if (dut.ghr !== 3'b101) begin failures++; $display("FAIL misiss_ghr got=%b exp=101", dut.ghr); end
      checks++; if (dut.pht[9] !== 2'b01) begin failures++; $display("FAIL misiss_pht got=%b exp=01", dut.pht[9]); end
   endtask

   task automatic test_back_to_back();
      drive(32'd12, 12'd5, 1'b1, 1'b0, 1'b0);
      tick();
      drive(32'd12, 12'd5, 1'b1, 1'b1, 1'b1);
      checks++; if (br_taken_o !== 1'b1) begin failures++; $display("FAIL b2b_taken got=%b exp=1", br_taken_o); end
      tick();
      drive(32'd0, 12'd0, 1'b0, 1'b1, 1'b1);
      checks++; if (inflight_o !== 3'd1) begin failures++; $display("FAIL b2b_inflight got=%0d exp=1", inflight_o); end
      checks++; if (dut.pht[3] !== 2'b11) begin failures++; $display("FAIL b2b_pht_inc got=%b exp=11", dut.pht[3]); end
      tick();
      drive(32'd0, 12'd0, 1'b0, 1'b0, 1'b0);
      checks++; if (dut.pht[3] !== 2'b11) begin failures++; $display("FAIL b2b_pht_sat got=%b exp=11", dut.pht[3]); end
      checks++; if (inflight_o !== 3'd0) begin failures++; $display("FAIL b2b_drain got=%0d exp=0", inflight_o); end
   endtask

   task automatic test_same_index();
      drive(32'd12, 12'd5, 1'b1, 1'b0, 1'b0);
      tick();
      drive(32'd12, 12'd5, 1'b1, 1'b1, 1'b0);
      checks++; if (br_taken_o !== 1'b1) begin failures++; $display("FAIL same_pre11 got=%b exp=1", br_taken_o); end
      checks++; if (recover_pc_o !== 32'd16) begin failures++; $display("FAIL same_recover got=%0d exp=16", recover_pc_o); end
      tick();
      drive(32'd0, 12'd0, 1'b0, 1'b0, 1'b0);
      checks++; if (dut.pht[3] !== 2'b10) begin failures++; $display("FAIL same_pht got=%b exp=10", dut.pht[3]); end
      checks++; if (dut.ghr !== 3'b110) begin failures++; $display("FAIL same_ghr got=%b exp=110", dut.ghr); end
      drive(32'd12, 12'd5, 1'b1, 1'b0, 1'b0);
      tick();
      drive(32'd12, 12'd5, 1'b1, 1'b1, 1'b0);
      checks++; if (br_taken_o !== 1'b1) begin failures++; $display("FAIL same_pre10 got=%b exp=1", br_taken_o); end
      tick();
      drive(32'd12, 12'd5, 1'b1, 1'b0, 1'b0);
      checks++; if (br_taken_o !== 1'b0) begin failures++; $display("FAIL same_post01 got=%b exp=0", br_taken_o); end
      checks++; if (program_counter_branched_o !== 32'd16) begin failures++; $display("FAIL same_pcb got=%0d exp=16", program_counter_branched_o); end
   endtask

   task automatic test_async_reset();
      tick();
      checks++; if (inflight_o !== 3'd1) begin failures++; $display("FAIL areset_pre got=%0d exp=1", inflight_o); end
      reset_i = 1'b1;
      #1;
      checks++; if (inflight_o !== 3'd0) begin failures++; $display("FAIL areset_inflight got=%0d exp=0", inflight_o); end
      checks++; if (dut.ghr !== 3'b000) begin failures++; $display("FAIL areset_ghr got=%b exp=000", dut.ghr); end
      reset_i = 1'b0;
      drive(32'd0, 12'd0, 1'b0, 1'b0, 1'b0);
      tick();
   endtask

   initial begin
      test_reset();
      test_empty_resolve();
      test_alloc();
      test_mispredict();
      test_full();
      test_full_resolve();
      test_mispredict_issue();
      test_back_to_back();
      test_same_index();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
